io_port: RTL and testbench
==========================

Name: io_port

Overview:
- Memory-mapped I/O slave directly downstream of the CPU core's byte-wide memory bus.
- Decodes accesses with mem_a[17:16]==2'b11, buffers output bytes toward the UART transmitter and input bytes from the UART receiver, and serves the cycle counter.
- Drives io_buffer_full back into the core.
- Handles the program-stop write, draining output before raising program_finish.

Parameters:
- TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries).
- FULL_MARGIN, 2, free TX entries below which io_buffer_full asserts.

Ports:
- clk_in  in  1  system clock; all state updates on rising edge.
- rst_in  in  1  synchronous reset, active-low (0 = reset).
- rdy_in  in  1  bus cycle qualifier; no access is taken when low.
- cpu_mem_a  in  32  CPU address bus.
- cpu_mem_dout  in  8  CPU write data.
- cpu_mem_wr  in  1  1 = write, 0 = read.
- io_dout  out  8  read data for the access presented in the previous cycle.
- io_rsp_sel  out  1  1 = previous-cycle access was an I/O read; the top muxes io_dout onto mem_din.
- io_buffer_full  out  1  TX FIFO nearly full; the CPU stalls.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid & tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid for one cycle.
- program_finish  out  1  sticky; program stopped and all output drained.
- tx_overflow  out  1  sticky; a TX byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_in==0 at a clock edge), all of the following:
  - Outputs: io_dout=0, io_rsp_sel=0, io_buffer_full=0, tx_valid=0, tx_data=0, program_finish=0, tx_overflow=0.
  - Both FIFOs empty, cycle counter=0, state=RUN.
  - Reset mid-transfer discards all FIFO contents.
- Access definition: an I/O access occurs in a cycle with rst_in=1, rdy_in=1 and cpu_mem_a[17:16]==2'b11. Only cpu_mem_a[2:0] is decoded further. The CPU presents each access for exactly one qualifying cycle.
- Write, offset 0:
  - cpu_mem_dout != 0: push to TX FIFO.
  - cpu_mem_dout == 0: ignored.
- Write, offset 4: push 0x00 to the TX FIFO and move RUN -> DRAIN.
- Write, other offsets: ignored.
- Read, offset 0: pop the RX FIFO; io_dout = popped byte in the next cycle. If the FIFO is empty, io_dout=0x00 and no pop occurs.
- Read, offsets 4..7: return cycle-counter byte (offset-4) (little-endian) in the next cycle.
  - The offset-4 read snapshots the full 32-bit counter into a latch.
  - Offsets 5..7 return bytes of that latch, so a 4-byte read sequence is coherent.
- Other read offsets return 0x00.
- io_rsp_sel = 1 exactly one cycle after any I/O read; 0 otherwise, including after writes and non-I/O reads.
- Read latency is 1 cycle, matching RAM.
- Cycle counter: 32-bit, +1 every cycle out of reset, independent of rdy_in, wraps 0xFFFFFFFF -> 0.
- TX FIFO behaviour:
  - Drives tx_valid = !empty and tx_data = head; pops when tx_valid & tx_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A push when count == depth is dropped and sets tx_overflow. A simultaneous pop frees space, so a push is not dropped in that case.
- io_buffer_full = (TX count >= 2^TX_DEPTH_LOG2 - FULL_MARGIN), derived from the registered count (combinational compare).
- RX FIFO behaviour:
  - Pushes rx_data when rx_valid.
  - When full, the incoming byte is dropped silently.
  - Simultaneous push and pop are both honoured.
- State machine:
  - RUN: normal operation.
  - DRAIN: further CPU writes are ignored (no push); reads still serviced. When the TX FIFO is empty and tx_valid is low -> DONE.
  - DONE: program_finish=1 (registered, set the cycle DONE is entered). Stays until reset; writes ignored.
- Pointer widths are LOG2+1 bits; wrap-around is handled by the MSB compare. Full and empty are exact at depth and 0.

Test Plan:
- Output path: reset, then writes 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 -> tx stream is exactly 0x48, 0x69; 0x00 is never pushed; tx_overflow stays 0.
- Back-pressure: tx_ready=0, 14 nonzero writes to 0x30000.
  - io_buffer_full rises the cycle after the 14th push (count 14); 16 pushes leave the FIFO full.
  - A 17th push sets tx_overflow.
  - With tx_ready=1 the FIFO drains in order.
- Input path: rx_valid pulses with 0x31, 0x32, then three reads of 0x30000 -> io_dout 0x31, 0x32, 0x00 each one cycle later; io_rsp_sel=1 on those cycles.
- Counter coherence: force the counter to 0x000000FE, read 0x30004..0x30007 on consecutive cycles -> bytes FE, 00, 00, 00 from the snapshot although the live counter crosses 0x100; the counter wraps from 0xFFFFFFFF to 0.
- Stop: tx_ready=0, write 0x41 to 0x30000, then write to 0x30004, then write 0x42 to 0x30000 -> 0x42 is ignored.
  - Release tx_ready -> bytes 0x41 then 0x00 are sent, then program_finish=1 the cycle after the FIFO empties.
- Reset mid-drain: in DRAIN with 3 bytes queued, hold rst_in=0 for one cycle -> FIFOs empty, tx_valid=0, program_finish=0, counter=0, state RUN.

Source files
------------

// File: rtl/io_port.sv
// Memory-mapped I/O slave at mem_a[17:16]==2'b11: TX/RX byte FIFOs toward the UART,
// a free-running cycle counter with a coherent read snapshot, and the program-stop drain.
module io_port #(
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int RX_DEPTH_LOG2 = 4,
   parameter int FULL_MARGIN   = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] cpu_mem_a,
   input  logic [7:0]  cpu_mem_dout,
   input  logic        cpu_mem_wr,
   output logic [7:0]  io_dout,
   output logic        io_rsp_sel,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        program_finish,
   output logic        tx_overflow
);

   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
   localparam int TX_CNT_W = TX_DEPTH_LOG2 + 1;
   localparam int RX_CNT_W = RX_DEPTH_LOG2 + 1;
   localparam logic [TX_CNT_W-1:0] FULL_LEVEL = TX_CNT_W'(TX_DEPTH - FULL_MARGIN);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t state;

   logic [7:0]          tx_mem [TX_DEPTH];
   logic [TX_CNT_W-1:0] tx_wr_ptr;
   logic [TX_CNT_W-1:0] tx_rd_ptr;
   logic [TX_CNT_W-1:0] tx_count;
   logic                tx_empty;
   logic                tx_full;
   logic                tx_push_req;
   logic                tx_push;
   logic                tx_pop;
   logic                tx_drop;
   logic [7:0]          tx_push_data;

   logic [7:0]          rx_mem [RX_DEPTH];
   logic [RX_CNT_W-1:0] rx_wr_ptr;
   logic [RX_CNT_W-1:0] rx_rd_ptr;
   logic                rx_empty;
   logic                rx_full;
   logic                rx_push;
   logic                rx_pop;
   logic [7:0]          rx_head;

   logic [31:0] cycle_count;
   logic [31:0] count_snap;

   logic        io_access;
   logic        wr_access;
   logic        rd_access;
   logic [2:0]  offset;
   logic        unused_addr;

   assign unused_addr = ^{cpu_mem_a[31:18], cpu_mem_a[15:3]};

   assign io_access = rdy_in && (cpu_mem_a[17:16] == 2'b11);
   assign wr_access = io_access && cpu_mem_wr;
   assign rd_access = io_access && !cpu_mem_wr;
   assign offset    = cpu_mem_a[2:0];

   // Pointers carry one extra bit so full (MSBs differ) and empty (equal) are distinct.
   assign tx_count = tx_wr_ptr - tx_rd_ptr;
   assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
   assign tx_full  = (tx_wr_ptr == {~tx_rd_ptr[TX_CNT_W-1], tx_rd_ptr[TX_CNT_W-2:0]});
   assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
   assign rx_full  = (rx_wr_ptr == {~rx_rd_ptr[RX_CNT_W-1], rx_rd_ptr[RX_CNT_W-2:0]});
   assign rx_head  = rx_mem[rx_rd_ptr[RX_DEPTH_LOG2-1:0]];

   assign tx_valid       = !tx_empty;
   assign tx_data        = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr[TX_DEPTH_LOG2-1:0]];
   assign io_buffer_full = (tx_count >= FULL_LEVEL);

   // The stop write enqueues a 0x00 marker; a zero data byte at offset 0 is not output.
   assign tx_push_req  = wr_access && (state == RUN) &&
                         (((offset == 3'd0) && (cpu_mem_dout != 8'h00)) || (offset == 3'd4));
   assign tx_push_data = (offset == 3'd4) ? 8'h00 : cpu_mem_dout;
   assign tx_pop       = !tx_empty && tx_ready;
   assign tx_push      = tx_push_req && (!tx_full || tx_pop);
   assign tx_drop      = tx_push_req && tx_full && !tx_pop;

   assign rx_pop  = rd_access && (offset == 3'd0) && !rx_empty;
   assign rx_push = rx_valid && (!rx_full || rx_pop);

   always_ff @(posedge clk_in) begin
      if (tx_push) begin
         tx_mem[tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= tx_push_data;
      end
      if (rx_push) begin
         rx_mem[rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         rx_wr_ptr   <= '0;
         rx_rd_ptr   <= '0;
         tx_overflow <= 1'b0;
         cycle_count <= 32'd0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_CNT_W'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_CNT_W'(1);
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_CNT_W'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_CNT_W'(1);
         if (tx_drop) tx_overflow <= 1'b1;
         cycle_count <= cycle_count + 32'd1;
      end
   end

   // Offset 4 latches the whole counter so the following 5..7 reads form one coherent value.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         io_dout    <= 8'h00;
         io_rsp_sel <= 1'b0;
         count_snap <= 32'd0;
      end else begin
         io_rsp_sel <= rd_access;
         io_dout    <= 8'h00;
         if (rd_access) begin
            case (offset)
               3'd0: io_dout <= rx_empty ? 8'h00 : rx_head;
               3'd4: begin
                  io_dout    <= cycle_count[7:0];
                  count_snap <= cycle_count;
               end
               3'd5: io_dout <= count_snap[15:8];
               3'd6: io_dout <= count_snap[23:16];
               3'd7: io_dout <= count_snap[31:24];
               default: io_dout <= 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state          <= RUN;
         program_finish <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (wr_access && (offset == 3'd4)) state <= DRAIN;
            end
            DRAIN: begin
               if (tx_empty) begin
                  state          <= DONE;
                  program_finish <= 1'b1;
               end
            end
            DONE: begin
               program_finish <= 1'b1;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_io_port.sv
// Directed testbench for io_port: output/input paths, back-pressure, counter snapshot,
// program stop and reset during drain.
module tb_io_port;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] cpu_mem_a;
   logic [7:0]  cpu_mem_dout;
   logic        cpu_mem_wr;
   logic [7:0]  io_dout;
   logic        io_rsp_sel;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        program_finish;
   logic        tx_overflow;

   int tests = 0;
   int fails = 0;
   logic [7:0] tx_seen [$];

   io_port dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .cpu_mem_a     (cpu_mem_a),
      .cpu_mem_dout  (cpu_mem_dout),
      .cpu_mem_wr    (cpu_mem_wr),
      .io_dout       (io_dout),
      .io_rsp_sel    (io_rsp_sel),
      .io_buffer_full(io_buffer_full),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .program_finish(program_finish),
      .tx_overflow   (tx_overflow)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Record every byte the transmitter will accept at the coming rising edge.
   always @(negedge clk_in) begin
      #4;
      if (rst_in === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) tx_seen.push_back(tx_data);
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic bus_idle();
      rdy_in       = 1'b0;
      cpu_mem_a    = 32'h0;
      cpu_mem_dout = 8'h00;
      cpu_mem_wr   = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
      rdy_in       = 1'b1;
      cpu_mem_a    = a;
      cpu_mem_dout = d;
      cpu_mem_wr   = 1'b1;
      @(negedge clk_in);
      bus_idle();
   endtask

   task automatic bus_read(input logic [31:0] a);
      rdy_in       = 1'b1;
      cpu_mem_a    = a;
      cpu_mem_dout = 8'h00;
      cpu_mem_wr   = 1'b0;
      @(negedge clk_in);
      bus_idle();
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      rx_valid = 1'b1;
      rx_data  = d;
      @(negedge clk_in);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      bus_idle();
      rx_valid = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   task automatic test_reset();
      tx_ready = 1'b0;
      do_reset();
      tests++;
      if ({io_dout, tx_data} !== 16'h0000) begin
         fails++;
         $display("[TB] FAIL reset_data: io_dout=%h tx_data=%h, required 00/00", io_dout, tx_data);
      end
      tests++;
      if ({io_rsp_sel, io_buffer_full, tx_valid, program_finish, tx_overflow} !== 5'b00000) begin
         fails++;
         $display("[TB] FAIL reset_flags: rsp/full/valid/finish/ovf=%b, required 00000",
                  {io_rsp_sel, io_buffer_full, tx_valid, program_finish, tx_overflow});
      end
   endtask

   task automatic test_output_path();
      do_reset();
      tx_ready = 1'b1;
      tx_seen.delete();
      bus_write(32'h30000, 8'h48);
      tests++;
      if (io_rsp_sel !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rsp_after_write: got %b required 0", io_rsp_sel);
      end
      bus_write(32'h30000, 8'h00);
      bus_write(32'h30000, 8'h69);
      repeat (4) @(negedge clk_in);
      tests++;
      if (tx_seen.size() != 2 || tx_seen[0] !== 8'h48 || tx_seen[1] !== 8'h69) begin
         fails++;
         $display("[TB] FAIL out_stream: got %p required '{48,69}", tx_seen);
      end
      tests++;
      if (tx_overflow !== 1'b0 || tx_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL out_idle: ovf=%b valid=%b required 0/0", tx_overflow, tx_valid);
      end
   endtask

   task automatic test_back_pressure();
      int bad;
      do_reset();
      tx_ready = 1'b0;
      tx_seen.delete();
      for (int i = 1; i <= 13; i++) bus_write(32'h30000, 8'(i));
      tests++;
      if (io_buffer_full !== 1'b0) begin
         fails++;
         $display("[TB] FAIL full_at_13: got %b required 0", io_buffer_full);
      end
      bus_write(32'h30000, 8'd14);
      tests++;
      if (io_buffer_full !== 1'b1) begin
         fails++;
         $display("[TB] FAIL full_at_14: got %b required 1", io_buffer_full);
      end
      bus_write(32'h30000, 8'd15);
      bus_write(32'h30000, 8'd16);
      tests++;
      if (tx_overflow !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'd1) begin
         fails++;
         $display("[TB] FAIL at_16: ovf=%b valid=%b data=%h required 0/1/01",
                  tx_overflow, tx_valid, tx_data);
      end
      bus_write(32'h30000, 8'd17);
      tests++;
      if (tx_overflow !== 1'b1) begin
         fails++;
         $display("[TB] FAIL overflow_17: got %b required 1", tx_overflow);
      end
      tx_ready = 1'b1;
      repeat (20) @(negedge clk_in);
      bad = (tx_seen.size() != 16) ? 1 : 0;
      for (int i = 0; i < tx_seen.size(); i++) if (tx_seen[i] !== 8'(i + 1)) bad = 1;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("[TB] FAIL drain_order: got %p required 1..16", tx_seen);
      end
      tests++;
      if (io_buffer_full !== 1'b0 || tx_valid !== 1'b0 || tx_overflow !== 1'b1) begin
         fails++;
         $display("[TB] FAIL after_drain: full=%b valid=%b ovf=%b required 0/0/1",
                  io_buffer_full, tx_valid, tx_overflow);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      tx_ready = 1'b0;
      tx_seen.delete();
      for (int i = 0; i < 16; i++) bus_write(32'h30000, 8'(8'h80 + i));
      tx_ready = 1'b1;
      bus_write(32'h30000, 8'hAA);
      repeat (20) @(negedge clk_in);
      tests++;
      if (tx_overflow !== 1'b0 || tx_seen.size() != 17) begin
         fails++;
         $display("[TB] FAIL full_push_pop: ovf=%b count=%0d required 0/17", tx_overflow, tx_seen.size());
      end else begin
         tests++;
         if (tx_seen[16] !== 8'hAA || tx_seen[0] !== 8'h80) begin
            fails++;
            $display("[TB] FAIL full_push_pop_data: first=%h last=%h required 80/aa", tx_seen[0], tx_seen[16]);
         end
      end
   endtask

   task automatic test_input_path();
      logic [7:0] exp_rd [3] = '{8'h31, 8'h32, 8'h00};
      int bad;
      do_reset();
      rx_pulse(8'h31);
      rx_pulse(8'h32);
      for (int i = 0; i < 3; i++) begin
         bus_read(32'h30000);
         tests++;
         if (io_dout !== exp_rd[i] || io_rsp_sel !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rx_read%0d: dout=%h sel=%b required %h/1", i, io_dout, io_rsp_sel, exp_rd[i]);
         end
      end
      @(negedge clk_in);
      tests++;
      if (io_rsp_sel !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rsp_idle: got %b required 0", io_rsp_sel);
      end
      bus_read(32'h20000);
      tests++;
      if (io_rsp_sel !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rsp_non_io: got %b required 0", io_rsp_sel);
      end
      rx_pulse(8'h99);
      bus_read(32'h30001);
      tests++;
      if (io_dout !== 8'h00 || io_rsp_sel !== 1'b1) begin
         fails++;
         $display("[TB] FAIL other_offset: dout=%h sel=%b required 00/1", io_dout, io_rsp_sel);
      end
      bus_read(32'h30000);
      tests++;
      if (io_dout !== 8'h99) begin
         fails++;
         $display("[TB] FAIL rx_not_popped: got %h required 99", io_dout);
      end
      for (int i = 0; i < 17; i++) rx_pulse(8'(8'h40 + i));
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         bus_read(32'h30000);
         if (i < 16 && io_dout !== 8'(8'h40 + i)) bad = 1;
         if (i == 16 && io_dout !== 8'h00) bad = 1;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("[TB] FAIL rx_full_drop: last dout=%h required 40..4f then 00", io_dout);
      end
   endtask

   task automatic test_counter();
      logic [7:0] exp_b [4] = '{8'hFE, 8'h00, 8'h00, 8'h00};
      do_reset();
      repeat (254) @(negedge clk_in);
      for (int i = 0; i < 4; i++) begin
         bus_read(32'h30004 + 32'(i));
         tests++;
         if (io_dout !== exp_b[i]) begin
            fails++;
            $display("[TB] FAIL counter_byte%0d: got %h required %h", i, io_dout, exp_b[i]);
         end
      end
      bus_read(32'h30004);
      tests++;
      if (io_dout !== 8'h02) begin
         fails++;
         $display("[TB] FAIL counter_live_lo: got %h required 02", io_dout);
      end
      bus_read(32'h30005);
      tests++;
      if (io_dout !== 8'h01) begin
         fails++;
         $display("[TB] FAIL counter_live_b1: got %h required 01", io_dout);
      end
   endtask

   task automatic test_stop();
      do_reset();
      tx_ready = 1'b0;
      tx_seen.delete();
      bus_write(32'h30000, 8'h41);
      bus_write(32'h30004, 8'h55);
      bus_write(32'h30000, 8'h42);
      tests++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h41 || program_finish !== 1'b0) begin
         fails++;
         $display("[TB] FAIL stop_queued: valid=%b data=%h fin=%b required 1/41/0",
                  tx_valid, tx_data, program_finish);
      end
      tx_ready = 1'b1;
      repeat (2) @(negedge clk_in);
      tests++;
      if (program_finish !== 1'b0 || tx_valid !== 1'b0) begin
         fails++;
         $display("[TB] FAIL stop_early: fin=%b valid=%b required 0/0", program_finish, tx_valid);
      end
      @(negedge clk_in);
      tests++;
      if (program_finish !== 1'b1) begin
         fails++;
         $display("[TB] FAIL stop_finish: got %b required 1", program_finish);
      end
      tests++;
      if (tx_seen.size() != 2 || tx_seen[0] !== 8'h41 || tx_seen[1] !== 8'h00) begin
         fails++;
         $display("[TB] FAIL stop_stream: got %p required '{41,00}", tx_seen);
      end
      bus_write(32'h30000, 8'h55);
      repeat (3) @(negedge clk_in);
      tests++;
      if (tx_seen.size() != 2 || program_finish !== 1'b1) begin
         fails++;
         $display("[TB] FAIL done_sticky: count=%0d fin=%b required 2/1", tx_seen.size(), program_finish);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      tx_ready = 1'b0;
      bus_write(32'h30000, 8'h01);
      bus_write(32'h30000, 8'h02);
      bus_write(32'h30004, 8'h00);
      rx_pulse(8'h77);
      rst_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      tests++;
      if ({tx_valid, program_finish, io_buffer_full, tx_overflow} !== 4'b0000 || tx_data !== 8'h00) begin
         fails++;
         $display("[TB] FAIL mid_reset_flags: valid/fin/full/ovf=%b data=%h required 0000/00",
                  {tx_valid, program_finish, io_buffer_full, tx_overflow}, tx_data);
      end
      bus_read(32'h30000);
      tests++;
      if (io_dout !== 8'h00) begin
         fails++;
         $display("[TB] FAIL mid_reset_rx: got %h required 00", io_dout);
      end
      bus_read(32'h30004);
      tests++;
      if (io_dout !== 8'h01) begin
         fails++;
         $display("[TB] FAIL mid_reset_counter: got %h required 01", io_dout);
      end
      tx_ready = 1'b1;
      tx_seen.delete();
      bus_write(32'h30000, 8'h5A);
      repeat (3) @(negedge clk_in);
      tests++;
      if (tx_seen.size() != 1 || tx_seen[0] !== 8'h5A || program_finish !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mid_reset_run: got %p fin=%b required '{5a}/0", tx_seen, program_finish);
      end
   endtask

   initial begin
      rst_in   = 1'b0;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      bus_idle();
      test_reset();
      test_output_path();
      test_back_pressure();
      test_full_push_pop();
      test_input_path();
      test_counter();
      test_stop();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
